mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Operand sequencer and result collector that drives mac_module from the initiator side. It buffers signed A/B operand pairs pushed by the host, then runs one dot-product job: it preloads the bias via RST_MAC, streams LEN pairs with EN_MAC asserted, and captures the saturated 16-bit Y. The result is returned to the host over a valid/ready handshake. It sits between the host/scheduler and one mac_module instance.

Parameters:
DEPTH, 16, operand-pair buffer entries (power of 2, ≥2)
LEN_W, 5, width of job length field (must hold DEPTH)

Ports:
CLKEXT  in  1  single system clock, rising edge
RSTN  in  1  asynchronous active-low reset
LD_VALID  in  1  host offers operand pair
LD_READY  out  1  buffer not full
LD_A  in  8  signed operand A
LD_B  in  8  signed operand B
START  in  1  job request, sampled only in IDLE
LEN  in  LEN_W  number of pairs to accumulate
BIAS  in  8  bias for the job
BUSY  out  1  state ≠ IDLE
ERR  out  1  one-cycle pulse: START with LEN > COUNT
COUNT  out  LEN_W+1  pairs currently buffered
OUT_VALID  out  1  RESULT valid
OUT_READY  in  1  host accepts RESULT
RESULT  out  16  signed captured Y
MAC_EN  out  1  to mac_module EN_MAC
MAC_RST  out  1  to mac_module RST_MAC (active-high, synchronous in MAC)
MAC_BIAS  out  8  to mac_module BIAS_IN
MAC_A  out  8  to mac_module A
MAC_B  out  8  to mac_module B
MAC_Y  in  16  from mac_module Y

Behaviour:
- Async reset (RSTN=0): state IDLE; all outputs 0 except LD_READY=1; buffer pointers and COUNT cleared; RESULT=0. Reset mid-job abandons the job. The MAC is not cleared; the next job always reloads the bias.
- All MAC_* outputs are registered. The MAC samples them on the following edge.
- Buffer: circular, DEPTH entries, wr/rd pointers wrap modulo DEPTH. Push when LD_VALID&LD_READY. Pop only in RUN. Simultaneous push and pop leaves COUNT unchanged. Push is allowed in any state. LD_READY = (COUNT < DEPTH), or a pop is occurring in the same cycle.
- FSM: IDLE, BIAS, RUN, WAIT, CAPT, OUT.
- IDLE: if START and LEN ≤ COUNT, latch LEN and BIAS, go to BIAS. If START and LEN > COUNT, pulse ERR and stay in IDLE.
- BIAS (1 cycle): drive MAC_RST=1, MAC_EN=1, MAC_BIAS=latched BIAS, MAC_A=MAC_B=0. The MAC loads the zero-extended bias at the next edge.
- RUN (LEN cycles): drive MAC_RST=0, MAC_EN=1, MAC_A/MAC_B = buffer head, pop once per cycle, decrement the remaining counter. Exit to WAIT when the remaining count reaches 0. If LEN=0, BIAS goes directly to WAIT.
- WAIT (1 cycle): MAC_EN=0, MAC_A=MAC_B=0. Lets the final MAC edge settle Y.
- CAPT: RESULT ← MAC_Y, OUT_VALID ← 1, go to OUT.
- OUT: hold RESULT and OUT_VALID until OUT_READY. On the handshake edge, clear OUT_VALID and go to IDLE. START is ignored outside IDLE.
- Latency: START edge → OUT_VALID high = LEN+4 edges (START, BIAS, LEN×RUN, WAIT, CAPT).
- Saturation is performed by mac_module. RESULT is MAC_Y unmodified, signed 16-bit.
- Outside BIAS/RUN, MAC_EN=0, so the MAC holds its value.

Decomposition:
- Shared package npu_pkg: FSM state encoding constants, operand width (8), accumulator width (16), SAT_POS=16'h7FFF, SAT_NEG=16'h8000.
- One natural sub-module: mac_op_fifo (DEPTH×16-bit circular buffer with COUNT, push/pop, full/empty).
- mac_seq_ctrl contains the FSM and instantiates mac_op_fifo.

Test Plan:
- Basic dot product: push (2,3), START LEN=1 BIAS=10 → MAC_RST high for exactly one cycle, OUT_VALID at START+5 edges, RESULT=16 (0x0010).
- Positive saturation: push 3×(127,127), START LEN=3 BIAS=0 → RESULT=0x7FFF; COUNT back to 0.
- Negative saturation, plus mac_module reset-to-0 check:
  - Push 3×(-128,127), START LEN=3 BIAS=0 → RESULT=0x8000.
  - Then START LEN=0 BIAS=0 → RESULT=0.
- Bias-only and error path:
  - START LEN=0 BIAS=5 → RESULT=5 after 4 edges.
  - With COUNT=2, START LEN=3 → ERR pulse one cycle, BUSY stays 0, COUNT=2.
- Buffer full and wrap:
  - Push DEPTH pairs (1,1) → LD_READY=0 and an extra push is ignored.
  - Run LEN=DEPTH BIAS=0 → RESULT=16.
  - Push and pop across the pointer wrap and check operand order is preserved.
- Backpressure and reset:
  - Hold OUT_READY=0 for 5 cycles → RESULT and OUT_VALID stable, START ignored.
  - Assert RSTN=0 mid-RUN → immediate IDLE, COUNT=0, MAC_EN=0.

Source files
------------

// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared definitions for the MAC operand sequencer: operand and
//               accumulator widths, saturation limits of mac_module, the
//               sequencer state encoding and an operand-pair packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 16;

  // Limits that mac_module clamps Y to.
  localparam logic [ACC_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [ACC_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIAS = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_CAPT = 3'd4,
    ST_OUT  = 3'd5
  } seq_state_t;

  // Buffer entries keep A in the upper byte and B in the lower byte.
  function automatic logic [2*OP_W-1:0] pack_pair(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
    return {a, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mac_op_fifo
// Description : Circular operand-pair buffer, DEPTH entries of DATA_W bits.
//               Pointers wrap modulo DEPTH (DEPTH is a power of two).
//               A push into a full buffer is accepted only when a pop
//               happens in the same cycle.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               push, wr_data - write request and data
//               pop, rd_data  - read request and head entry (show-ahead)
//               count         - entries held
//               full, empty   - occupancy flags
// ============================================================================
module mac_op_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // When full, wr_ptr equals rd_ptr; the head is read out before the edge
  // that overwrites it, so push-while-full is safe only alongside a pop.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_ctrl
// Description : Operand sequencer / result collector in front of one
//               mac_module. Buffers A/B pairs from the host, runs a job of
//               LEN pairs (bias preload, LEN accumulate cycles, settle,
//               capture) and returns Y over a valid/ready handshake.
// Revision    : 1.0 - initial release
// Ports       : CLKEXT, RSTN            - clock, asynchronous active-low reset
//               LD_VALID/READY, LD_A/B  - operand-pair push interface
//               START, LEN, BIAS        - job request (sampled in IDLE)
//               BUSY, ERR, COUNT        - status
//               OUT_VALID/READY, RESULT - result handshake
//               MAC_EN/RST/BIAS/A/B     - registered drive into mac_module
//               MAC_Y                   - accumulator output of mac_module
// ============================================================================
module mac_seq_ctrl
  import npu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             CLKEXT,
  input  logic             RSTN,
  input  logic             LD_VALID,
  output logic             LD_READY,
  input  logic [OP_W-1:0]  LD_A,
  input  logic [OP_W-1:0]  LD_B,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic [OP_W-1:0]  BIAS,
  output logic             BUSY,
  output logic             ERR,
  output logic [LEN_W:0]   COUNT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ACC_W-1:0] RESULT,
  output logic             MAC_EN,
  output logic             MAC_RST,
  output logic [OP_W-1:0]  MAC_BIAS,
  output logic [OP_W-1:0]  MAC_A,
  output logic [OP_W-1:0]  MAC_B,
  input  logic [ACC_W-1:0] MAC_Y
);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [LEN_W-1:0]  r_remain;
  logic [OP_W-1:0]   r_bias;
  logic              r_err;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_result;
  logic              r_mac_en;
  logic              r_mac_rst;
  logic [OP_W-1:0]   r_mac_bias;
  logic [OP_W-1:0]   r_mac_a;
  logic [OP_W-1:0]   r_mac_b;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [2*OP_W-1:0] w_head;
  logic [LEN_W:0]    w_count;
  logic              w_fits;
  logic              w_accept;

  // --------------------------------------------------------------------------
  // Operand buffer
  // --------------------------------------------------------------------------
  assign w_pop    = (r_state == ST_RUN) && !w_empty;
  assign LD_READY = !w_full || w_pop;
  assign w_push   = LD_VALID && LD_READY;

  mac_op_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2 * OP_W),
    .CNT_W  (LEN_W + 1)
  ) u_fifo (
    .clk     (CLKEXT),
    .rst_n   (RSTN),
    .push    (w_push),
    .wr_data (pack_pair(LD_A, LD_B)),
    .pop     (w_pop),
    .rd_data (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // A job is only accepted when every pair it needs is already buffered, so
  // RUN never has to stall on an empty buffer.
  assign w_fits   = ({1'b0, LEN} <= w_count);
  assign w_accept = (r_state == ST_IDLE) && START && w_fits;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLKEXT or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)                   w_next = ST_BIAS;
      ST_BIAS: w_next = (r_remain == '0) ? ST_WAIT : ST_RUN;
      ST_RUN:  if (r_remain == LEN_W'(1))      w_next = ST_WAIT;
      ST_WAIT: w_next = ST_CAPT;
      ST_CAPT: w_next = ST_OUT;
      ST_OUT:  if (OUT_READY)                  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Job registers and registered MAC drive. The MAC outputs follow the
  // current state one edge later, so mac_module sees the bias load during
  // the cycle after BIAS and the last pair during WAIT; CAPT then reads a
  // settled Y.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLKEXT or negedge RSTN) begin
    if (!RSTN) begin
      r_remain    <= '0;
      r_bias      <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_mac_en    <= 1'b0;
      r_mac_rst   <= 1'b0;
      r_mac_bias  <= '0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
    end else begin
      r_err      <= (r_state == ST_IDLE) && START && !w_fits;
      r_mac_en   <= (r_state == ST_BIAS) || (r_state == ST_RUN);
      r_mac_rst  <= (r_state == ST_BIAS);
      r_mac_bias <= (r_state == ST_BIAS) ? r_bias : '0;
      r_mac_a    <= w_pop ? w_head[2*OP_W-1:OP_W] : '0;
      r_mac_b    <= w_pop ? w_head[OP_W-1:0]      : '0;

      if (w_accept) begin
        r_remain <= LEN;
        r_bias   <= BIAS;
      end else if (r_state == ST_RUN) begin
        r_remain <= r_remain - LEN_W'(1);
      end

      if (r_state == ST_CAPT) begin
        r_result    <= MAC_Y;
        r_out_valid <= 1'b1;
      end else if ((r_state == ST_OUT) && OUT_READY) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign BUSY      = (r_state != ST_IDLE);
  assign ERR       = r_err;
  assign COUNT     = w_count;
  assign OUT_VALID = r_out_valid;
  assign RESULT    = r_result;
  assign MAC_EN    = r_mac_en;
  assign MAC_RST   = r_mac_rst;
  assign MAC_BIAS  = r_mac_bias;
  assign MAC_A     = r_mac_a;
  assign MAC_B     = r_mac_b;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq_ctrl
// Description : Self-checking bench for mac_seq_ctrl with a behavioural
//               saturating MAC attached to the MAC_* interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

  localparam int DEPTH = 16;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             ld_valid;
  logic             ld_ready;
  logic [7:0]       ld_a;
  logic [7:0]       ld_b;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       bias;
  logic             busy;
  logic             err;
  logic [LEN_W:0]   count;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      result;
  logic             mac_en;
  logic             mac_rst;
  logic [7:0]       mac_bias;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic [15:0]      mac_y = 16'h0000;

  int n_total = 0;
  int n_pass  = 0;
  int rst_cycles = 0;
  logic cap_on = 1'b0;
  logic [7:0] cap_a[$];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .CLKEXT    (clk),
    .RSTN      (rstn),
    .LD_VALID  (ld_valid),
    .LD_READY  (ld_ready),
    .LD_A      (ld_a),
    .LD_B      (ld_b),
    .START     (start),
    .LEN       (len),
    .BIAS      (bias),
    .BUSY      (busy),
    .ERR       (err),
    .COUNT     (count),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .RESULT    (result),
    .MAC_EN    (mac_en),
    .MAC_RST   (mac_rst),
    .MAC_BIAS  (mac_bias),
    .MAC_A     (mac_a),
    .MAC_B     (mac_b),
    .MAC_Y     (mac_y)
  );

  // Behavioural mac_module: bias load (zero-extended) or saturating MAC.
  function automatic logic [15:0] mac_step(input logic [15:0] y,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    int iy, ia, ib, s;
    iy = $signed(y);
    ia = $signed(a);
    ib = $signed(b);
    s  = iy + ia * ib;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  always @(posedge clk) begin
    if (mac_en) begin
      if (mac_rst) mac_y <= {8'h00, mac_bias};
      else         mac_y <= mac_step(mac_y, mac_a, mac_b);
    end
  end

  always @(negedge clk) begin
    if (mac_rst) rst_cycles++;
    if (cap_on && mac_en && !mac_rst) cap_a.push_back(mac_a);
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          n;
    int          jlen;
    logic [7:0]  jbias;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    ld_valid = 1'b1;
    ld_a     = a;
    ld_b     = b;
    tick();
    ld_valid = 1'b0;
  endtask

  // Issues START and returns the edge count (START edge = 1) to OUT_VALID.
  task automatic run_job(input int jlen, input logic [7:0] jbias,
                         output int lat);
    start = 1'b1;
    len   = LEN_W'(jlen);
    bias  = jbias;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int c_before;

    vecs[0] = '{a: 8'd2,   b: 8'd3,   n: 1, jlen: 1, jbias: 8'd10,  exp: 16'h0010};
    vecs[1] = '{a: 8'd127, b: 8'd127, n: 3, jlen: 3, jbias: 8'd0,   exp: 16'h7FFF};
    vecs[2] = '{a: 8'h80,  b: 8'd127, n: 3, jlen: 3, jbias: 8'd0,   exp: 16'h8000};
    vecs[3] = '{a: 8'd0,   b: 8'd0,   n: 0, jlen: 0, jbias: 8'd0,   exp: 16'h0000};
    vecs[4] = '{a: 8'd0,   b: 8'd0,   n: 0, jlen: 0, jbias: 8'd5,   exp: 16'h0005};
    vecs[5] = '{a: 8'hFB,  b: 8'd7,   n: 2, jlen: 2, jbias: 8'd3,   exp: 16'hFFBD};
    vecs[6] = '{a: 8'd10,  b: 8'hFD,  n: 1, jlen: 1, jbias: 8'hFF,  exp: 16'h00E1};

    rstn = 1'b0; ld_valid = 1'b0; ld_a = '0; ld_b = '0;
    start = 1'b0; len = '0; bias = '0; out_ready = 1'b0;
    tick(); tick();
    check("reset busy", busy, 0);
    check("reset ld_ready", ld_ready, 1);
    check("reset count", count, 0);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset mac_en", mac_en, 0);
    check("reset err", err, 0);
    #2 rstn = 1'b1;
    tick();

    // Table-driven jobs.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < vecs[i].n; k++) push(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d count loaded", i), count, vecs[i].n);
      rst_cycles = 0;
      run_job(vecs[i].jlen, vecs[i].jbias, lat);
      check($sformatf("v%0d latency", i), lat, vecs[i].jlen + 4);
      check($sformatf("v%0d result", i), result, vecs[i].exp);
      check($sformatf("v%0d mac_rst cycles", i), rst_cycles, 1);
      check($sformatf("v%0d count drained", i), count, 0);
      accept();
      check($sformatf("v%0d out_valid cleared", i), out_valid, 0);
      check($sformatf("v%0d busy cleared", i), busy, 0);
    end

    // Error path: LEN exceeds buffered pairs.
    push(8'd4, 8'd5);
    push(8'd6, 8'd7);
    start = 1'b1; len = 5'd3; bias = 8'd0;
    tick();
    start = 1'b0;
    check("err pulse", err, 1);
    check("err busy", busy, 0);
    tick();
    check("err one cycle", err, 0);
    check("err count kept", count, 2);
    run_job(2, 8'd0, lat);
    check("err followup result", result, 16'd62);
    accept();

    // Full buffer.
    for (int k = 0; k < DEPTH - 1; k++) push(8'd1, 8'd1);
    check("almost full ready", ld_ready, 1);
    push(8'd1, 8'd1);
    check("full ready", ld_ready, 0);
    check("full count", count, DEPTH);
    push(8'd9, 8'd9);
    check("extra push ignored", count, DEPTH);
    run_job(DEPTH, 8'd0, lat);
    check("full job latency", lat, DEPTH + 4);
    check("full job result", result, 16'd16);
    accept();

    // Pointer wrap with order check and a push during RUN.
    for (int k = 0; k < 12; k++) push(8'(k + 1), 8'd2);
    cap_a.delete();
    cap_on = 1'b1;
    start = 1'b1; len = 5'd12; bias = 8'd0;
    tick();
    start = 1'b0;
    tick();
    c_before = count;
    ld_valid = 1'b1; ld_a = 8'd100; ld_b = 8'd0;
    tick();
    ld_valid = 1'b0;
    check("push+pop count", count, c_before);
    lat = 3;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    cap_on = 1'b0;
    check("wrap latency", lat, 16);
    check("wrap result", result, 16'd156);
    check("wrap pairs seen", cap_a.size(), 12);
    for (int k = 0; k < 12 && k < cap_a.size(); k++)
      check($sformatf("wrap order %0d", k), cap_a[k], k + 1);
    accept();
    check("wrap leftover", count, 1);

    // Backpressure: result holds and START is ignored.
    run_job(1, 8'd7, lat);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; len = 5'd0; bias = 8'd1;
      tick();
      check($sformatf("bp%0d out_valid", k), out_valid, 1);
      check($sformatf("bp%0d result", k), result, 16'd7);
    end
    start = 1'b0;
    check("bp busy", busy, 1);
    accept();
    check("bp released", busy, 0);
    check("bp no err", err, 0);

    // Reset in the middle of RUN.
    for (int k = 0; k < 4; k++) push(8'd1, 8'd1);
    start = 1'b1; len = 5'd4; bias = 8'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midrun mac_en before", mac_en, 1);
    #2 rstn = 1'b0;
    #1;
    check("midrun busy", busy, 0);
    check("midrun count", count, 0);
    check("midrun mac_en", mac_en, 0);
    check("midrun ld_ready", ld_ready, 1);
    #1 rstn = 1'b1;
    tick();
    rst_cycles = 0;
    run_job(0, 8'd9, lat);
    check("post reset latency", lat, 4);
    check("post reset result", result, 16'd9);
    check("post reset mac_rst", rst_cycles, 1);
    accept();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
